// File: rtl/uart_receiver.sv
// UART receive stage: 16x oversampled, false-start rejection, optional parity,
// stop-bit checking and one-clk result pulses for the RX FIFO and status register.
module uart_receiver #(
    parameter int DATA_BITS     = 8,
    parameter int STOP_BIT_TICK = 16,
    parameter int PARITY_EN     = 0,
    parameter int PARITY_ODD    = 0
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 rx,
    input  logic                 tick,
    input  logic                 rx_full,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_done_tick,
    output logic                 overrun_error,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 rx_idle
);

    localparam int S_W = $clog2(STOP_BIT_TICK);
    localparam int N_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t               state_q, state_d;
    logic [S_W-1:0]       s_q, s_d;
    logic [N_W-1:0]       n_q, n_d;
    logic [DATA_BITS-1:0] b_q, b_d;
    logic                 p_err_q, p_err_d;
    logic [DATA_BITS-1:0] dout_d;
    logic                 done_d, ovr_d, frm_d, par_d;
    logic                 rx_meta, rx_s;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_meta       <= 1'b1;
            rx_s          <= 1'b1;
            state_q       <= ST_IDLE;
            s_q           <= '0;
            n_q           <= '0;
            b_q           <= '0;
            p_err_q       <= 1'b0;
            dout          <= '0;
            rx_done_tick  <= 1'b0;
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
            parity_error  <= 1'b0;
            rx_idle       <= 1'b1;
        end else begin
            rx_meta       <= rx;
            rx_s          <= rx_meta;
            state_q       <= state_d;
            s_q           <= s_d;
            n_q           <= n_d;
            b_q           <= b_d;
            p_err_q       <= p_err_d;
            dout          <= dout_d;
            rx_done_tick  <= done_d;
            overrun_error <= ovr_d;
            frame_error   <= frm_d;
            parity_error  <= par_d;
            rx_idle       <= (state_d == ST_IDLE);
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        p_err_d = p_err_q;
        dout_d  = dout;
        done_d  = 1'b0;
        ovr_d   = 1'b0;
        frm_d   = 1'b0;
        par_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Start detection is not tick-gated, to catch the edge promptly.
                if (!rx_s) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s_q == S_W'(7)) begin
                        if (!rx_s) begin
                            state_d = ST_DATA;
                            s_d     = '0;
                            n_d     = '0;
                            p_err_d = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s_q == S_W'(15)) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DATA_BITS-1:1]};
                        if (n_q == N_W'(DATA_BITS - 1)) begin
                            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    if (s_q == S_W'(15)) begin
                        s_d     = '0;
                        p_err_d = rx_s ^ (^b_q) ^ (PARITY_ODD != 0);
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (s_q == S_W'(STOP_BIT_TICK - 1)) begin
                        s_d = '0;
                        if (!rx_s) begin
                            frm_d   = 1'b1;
                            state_d = ST_BREAK;
                        end else if (p_err_q) begin
                            par_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else if (rx_full) begin
                            ovr_d   = 1'b1;
                            dout_d  = b_q;
                            state_d = ST_IDLE;
                        end else begin
                            done_d  = 1'b1;
                            dout_d  = b_q;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                // A line held low yields one frame_error, not a stream of frames.
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized self-checking bench for uart_receiver: an 8N1 instance and an 8E1
// instance, checked against a frame-level outcome model.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       tick;
    logic       rx_a, rx_b;
    logic       full_a, full_b;
    logic [7:0] dout_a, dout_b;
    logic       done_a, ovr_a, frm_a, par_a, idle_a;
    logic       done_b, ovr_b, frm_b, par_b, idle_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed and expected pulse counts: [instance][done, overrun, frame, parity]
    int         obs_cnt[2][4];
    int         exp_cnt[2][4];
    logic [7:0] exp_dout[2];
    int         overlap = 0;

    always #5 clk = ~clk;

    uart_receiver #(
        .DATA_BITS(8), .STOP_BIT_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)
    ) dut_a (
        .clk(clk), .arst_n(arst_n), .rx(rx_a), .tick(tick), .rx_full(full_a),
        .dout(dout_a), .rx_done_tick(done_a), .overrun_error(ovr_a),
        .frame_error(frm_a), .parity_error(par_a), .rx_idle(idle_a)
    );

    uart_receiver #(
        .DATA_BITS(8), .STOP_BIT_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)
    ) dut_b (
        .clk(clk), .arst_n(arst_n), .rx(rx_b), .tick(tick), .rx_full(full_b),
        .dout(dout_b), .rx_done_tick(done_b), .overrun_error(ovr_b),
        .frame_error(frm_b), .parity_error(par_b), .rx_idle(idle_b)
    );

    // Pulses are sampled on the falling edge, one count per clk they stay high.
    always @(negedge clk) begin
        if (done_a) obs_cnt[0][0]++;
        if (ovr_a)  obs_cnt[0][1]++;
        if (frm_a)  obs_cnt[0][2]++;
        if (par_a)  obs_cnt[0][3]++;
        if (done_b) obs_cnt[1][0]++;
        if (ovr_b)  obs_cnt[1][1]++;
        if (frm_b)  obs_cnt[1][2]++;
        if (par_b)  obs_cnt[1][3]++;
        if ($countones({done_a, ovr_a, frm_a, par_a}) > 1) overlap++;
        if ($countones({done_b, ovr_b, frm_b, par_b}) > 1) overlap++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    function automatic logic idle_of(input bit sel);
        return sel ? idle_b : idle_a;
    endfunction

    task automatic check_model(input string tag);
        string names[4] = '{"done", "overrun", "frame", "parity"};
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 4; k++)
                check($sformatf("%s.%s.%s", tag, s ? "b" : "a", names[k]),
                      obs_cnt[s][k], exp_cnt[s][k]);
        end
        check({tag, ".a.dout"}, int'(dout_a), int'(exp_dout[0]));
        check({tag, ".b.dout"}, int'(dout_b), int'(exp_dout[1]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".dout"}, int'({dout_a, dout_b}), 0);
        check({tag, ".pulses"},
              int'({done_a, ovr_a, frm_a, par_a, done_b, ovr_b, frm_b, par_b}), 0);
        check({tag, ".idle"}, int'({idle_a, idle_b}), 3);
    endtask

    // Drives one full frame, then applies the frame-level rules to the model.
    task automatic send_frame(input bit sel, input logic [7:0] data, input bit stop_ok,
                              input bit par_ok, input bit full, input int hold_low,
                              input int gap, input string tag);
        bit bad_par;
        if (sel) full_b = full;
        else     full_a = full;
        drive(sel, 1'b0);
        clks(16);
        for (int i = 0; i < 8; i++) begin
            drive(sel, data[i]);
            clks(16);
        end
        if (sel) begin
            drive(sel, par_ok ? ^data : ~^data);
            clks(16);
        end
        drive(sel, stop_ok);
        clks(16);

        bad_par = sel && !par_ok;
        if (!stop_ok) begin
            exp_cnt[sel][2]++;
        end else if (bad_par) begin
            exp_cnt[sel][3]++;
        end else if (full) begin
            exp_cnt[sel][1]++;
            exp_dout[sel] = data;
        end else begin
            exp_cnt[sel][0]++;
            exp_dout[sel] = data;
        end
        check_model(tag);
        check({tag, ".idle_after_stop"}, int'(idle_of(sel)), int'(stop_ok));

        if (!stop_ok) begin
            clks(hold_low);
            check({tag, ".break_hold"}, int'(idle_of(sel)), 0);
            drive(sel, 1'b1);
            clks(4);
            check({tag, ".break_exit"}, int'(idle_of(sel)), 1);
            check_model({tag, ".after_break"});
        end
        drive(sel, 1'b1);
        if (sel) full_b = 1'b0;
        else     full_a = 1'b0;
        clks(gap);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 4; k++) begin
                obs_cnt[s][k] = 0;
                exp_cnt[s][k] = 0;
            end
            exp_dout[s] = 8'h00;
        end
        arst_n = 1'b0;
        tick   = 1'b1;
        rx_a   = 1'b1;
        rx_b   = 1'b1;
        full_a = 1'b0;
        full_b = 1'b0;
        clks(3);
        check_reset_outputs("reset");
        arst_n = 1'b1;
        clks(5);

        send_frame(1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 0, 10, "t1_good");

        // Short low glitch: START is entered, then abandoned at mid-bit.
        drive(1'b0, 1'b0);
        clks(4);
        drive(1'b0, 1'b1);
        clks(1);
        check("t2_glitch.busy", int'(idle_a), 0);
        clks(20);
        check("t2_glitch.idle", int'(idle_a), 1);
        check_model("t2_glitch");

        send_frame(1'b0, 8'hA3, 1'b0, 1'b1, 1'b0, 24, 10, "t3_break");
        send_frame(1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 0, 10, "t4_overrun");
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 0, 10, "t5_par_ok");
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 0, 10, "t5_par_bad");

        // Reset in the middle of the data bits of 0x81.
        drive(1'b0, 1'b0);
        clks(16);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h81 >> i);
            clks(16);
        end
        arst_n = 1'b0;
        drive(1'b0, 1'b1);
        clks(2);
        check_reset_outputs("t6_reset");
        exp_dout[0] = 8'h00;
        exp_dout[1] = 8'h00;
        clks(3);
        arst_n = 1'b1;
        clks(30);
        check_model("t6_after_reset");
        send_frame(1'b0, 8'hF0, 1'b1, 1'b1, 1'b0, 0, 10, "t6_next");

        for (int it = 0; it < 40; it++) begin
            bit         sel;
            logic [7:0] data;
            bit         stop_ok, par_ok, full;
            int         hold, gap;
            sel     = 1'($urandom_range(0, 1));
            data    = 8'($urandom);
            stop_ok = ($urandom_range(0, 7) != 0);
            par_ok  = ($urandom_range(0, 3) != 0);
            full    = ($urandom_range(0, 3) == 0);
            hold    = stop_ok ? 0 : int'($urandom_range(0, 30));
            gap     = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 20));
            send_frame(sel, data, stop_ok, par_ok, full, hold, gap,
                       $sformatf("rnd%0d", it));
        end

        clks(20);
        check("no_pulse_overlap", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
